uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Sits between the host UART line and the CPU core's memories.
- Deserialises UART_RX bytes and assembles big-endian 32-bit words.
- Writes the data section into data memory until the 0xFFFFFFFF delimiter, then writes the remaining words into instruction memory.
- On START_EXEC it releases the core; after that, received bytes are forwarded to the core as runtime input.

Parameters:
T, 130, clock cycles per UART bit (must be ≥4).
IADDR_W, 14, instruction memory word-address width.
DADDR_W, 14, data memory word-address width.

Ports:
CLK  in  1  system clock; all logic on posedge.
RST_N  in  1  reset, asynchronous assert, active-low.
UART_RX  in  1  serial input; idle high; 8N1, LSB first.
START_EXEC  in  1  level request to begin execution; the rising edge is used.
INST_WE  out  1  instruction memory write strobe, one cycle per word.
INST_ADDR  out  IADDR_W  instruction word address.
INST_DATA  out  32  instruction word.
DATA_WE  out  1  data memory write strobe, one cycle per word.
DATA_ADDR  out  DADDR_W  data word address.
DATA_DATA  out  32  data word.
CPU_START  out  1  one-cycle pulse that releases the core.
LOAD_DONE  out  1  high from CPU_START onward.
RX_BYTE  out  8  runtime byte for the core (valid in S_RUN only).
RX_VALID  out  1  one-cycle strobe with RX_BYTE.
LOAD_ERR  out  1  sticky error flag.

Behaviour:
- Reset: all outputs are 0. FSM = S_DATA, byte index = 0, address counters = 0, receiver idle. Reset mid-frame or mid-load aborts everything; no partial write is emitted.
- Synchroniser: UART_RX passes through 2 flops, reset value 1. Edge detection and sampling use only the synchronised signal.
- Receiver FSM RX_IDLE → RX_START → RX_BITS → RX_STOP → RX_IDLE:
  - RX_IDLE: a falling edge starts the frame.
  - RX_START: samples at count T/2 (integer division). If the line is 1, the start was a glitch; return to RX_IDLE with no error.
  - RX_BITS: takes 8 samples, each T cycles after the previous one, shifted in LSB first.
  - RX_STOP: samples T cycles after bit 7. Stop = 1 raises an internal byte_valid on that cycle. Stop = 0 discards the byte, sets LOAD_ERR, and waits in RX_IDLE for the line to return high before accepting a new start.
- Word assembler:
  - Byte index 0..3; byte 0 → word[31:24], byte 3 → word[7:0].
  - On the 4th byte, word_valid pulses on the following cycle and the index wraps to 0.
- Loader FSM:
  - S_DATA:
    - A word ≠ 0xFFFFFFFF produces DATA_WE=1 with DATA_ADDR = data counter, then the counter increments.
    - A word = 0xFFFFFFFF writes nothing and moves to S_INST.
  - S_INST: every word produces INST_WE=1 with INST_ADDR = instruction counter, then the counter increments. 0xFFFFFFFF is a legal instruction here and is written.
  - Write latency: the strobe is asserted exactly 1 cycle after word_valid. Address and data are valid in the same cycle as the strobe.
  - Counter overflow: when a counter is at its max value and the max address has already been written, further writes are suppressed and LOAD_ERR is set. Counters never wrap.
  - START_EXEC:
    - A rising edge in S_INST with byte index = 0 and no write pending this cycle produces CPU_START=1 on the next cycle, sets LOAD_DONE=1, and moves to S_RUN.
    - A rising edge in S_DATA, or with a partial word (index ≠ 0), is ignored and sets LOAD_ERR.
    - If the edge coincides with a word write, the write completes first and the edge is re-evaluated on the next cycle while START_EXEC is still high.
  - S_RUN:
    - Terminal until reset.
    - The word assembler is disabled; each byte_valid produces RX_VALID=1 with RX_BYTE on the next cycle.
    - INST_WE and DATA_WE stay 0.
    - START_EXEC is ignored.
- RX_VALID is never asserted outside S_RUN.
- LOAD_ERR clears only on reset.

Test Plan:
1. Reset, then send the 9 data words 0x00000000, 0x80000000, 0x3F800000, …, 0x00000000, delimiter 0xFFFFFFFF, then 3 instructions (first 0x4F84E200) → 9 DATA_WE pulses at addresses 0..8 with matching data, no write for the delimiter, 3 INST_WE pulses at addresses 0..2, LOAD_ERR=0.
2. After scenario 1, hold line idle 100 cycles, raise START_EXEC for 2 cycles → exactly one CPU_START pulse, LOAD_DONE=1 thereafter; then send byte 0x5A → RX_VALID one cycle with RX_BYTE=0x5A, no memory write.
3. Frame with stop bit forced to 0 (byte 0xA5) → no byte accepted, LOAD_ERR=1. Next valid 4 bytes 0x01,0x02,0x03,0x04 → DATA_WE with 0x01020304 at address 0.
4. 0-pulse of T/4 cycles on UART_RX while idle → no byte, LOAD_ERR stays 0. A following normal frame is received correctly.
5. START_EXEC edge after 2 bytes of an instruction word, and a separate edge in S_DATA → LOAD_ERR=1, no CPU_START, FSM state unchanged.
6. Assert RST_N=0 midway through byte 3 of an instruction word → all outputs 0. Reload from scratch → data writes start again at address 0, no stale partial word.

Source files
------------

// File: rtl/uart_program_loader.sv
// uart_program_loader: boot loader between the host UART and the core memories.
// Receives 8N1 bytes, packs them big-endian into 32-bit words, and writes data words
// to data memory until the 0xFFFFFFFF delimiter. After that, it writes words to
// instruction memory. A START_EXEC rising edge on a word boundary releases the core.
// Bytes received after that are forwarded as runtime input.
//
// Ports:
//   CLK, RST_N         clock, async active-low reset
//   UART_RX            serial input (idle high, LSB first)
//   START_EXEC         level request to start execution (rising edge used)
//   INST_WE/ADDR/DATA  instruction memory write port
//   DATA_WE/ADDR/DATA  data memory write port
//   CPU_START          one-cycle core release pulse
//   LOAD_DONE          high from CPU_START onward
//   RX_BYTE/RX_VALID   runtime byte stream (run mode only)
//   LOAD_ERR           sticky error flag
module uart_program_loader #(
    parameter int unsigned T       = 130,
    parameter int unsigned IADDR_W = 14,
    parameter int unsigned DADDR_W = 14
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               UART_RX,
    input  logic               START_EXEC,
    output logic               INST_WE,
    output logic [IADDR_W-1:0] INST_ADDR,
    output logic [31:0]        INST_DATA,
    output logic               DATA_WE,
    output logic [DADDR_W-1:0] DATA_ADDR,
    output logic [31:0]        DATA_DATA,
    output logic               CPU_START,
    output logic               LOAD_DONE,
    output logic [7:0]         RX_BYTE,
    output logic               RX_VALID,
    output logic               LOAD_ERR
);

    localparam int unsigned CntW = $clog2(T + 1);
    localparam logic [CntW-1:0] HalfT = CntW'(T / 2);
    localparam logic [CntW-1:0] LastT = CntW'(T - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxBits, RxStop} rx_state_e;
    typedef enum logic [1:0] {SData, SInst, SRun} ld_state_e;

    // ---------------- receiver ----------------
    logic            sync1_q, rx_s_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            wait_high_q, wait_high_d;
    logic            byte_valid, frame_err;

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q + CntW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                cnt_d = '0;
                // After a framing error the line must go high before a new start counts.
                if (wait_high_q) begin
                    if (rx_s_q) wait_high_d = 1'b0;
                end else if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (cnt_q == HalfT) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s_q ? RxIdle : RxBits;
                end
            end
            RxBits: begin
                if (cnt_q == LastT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == LastT) begin
                    cnt_d      = '0;
                    rx_state_d = RxIdle;
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err   = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wait_high_q <= 1'b0;
        end else begin
            sync1_q     <= UART_RX;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
        end
    end

    // ---------------- word assembler and loader ----------------
    ld_state_e          ld_state_q, ld_state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic [DADDR_W-1:0] dcnt_q, dcnt_d;
    logic [IADDR_W-1:0] icnt_q, icnt_d;
    logic               dfull_q, dfull_d, ifull_q, ifull_d;
    logic               start_prev_q, start_pend_q, start_pend_d;
    logic               err_q, err_d, done_q, done_d;
    logic               data_we_d, inst_we_d, cpu_start_d, rx_valid_d;
    logic [DADDR_W-1:0] data_addr_d;
    logic [IADDR_W-1:0] inst_addr_d;
    logic [31:0]        data_data_d, inst_data_d;
    logic [7:0]         rx_byte_d;
    logic               start_req;

    assign start_req = (START_EXEC && !start_prev_q) || start_pend_q;

    always_comb begin
        ld_state_d   = ld_state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        dcnt_d       = dcnt_q;
        icnt_d       = icnt_q;
        dfull_d      = dfull_q;
        ifull_d      = ifull_q;
        start_pend_d = 1'b0;
        err_d        = err_q | frame_err;
        done_d       = done_q;
        data_we_d    = 1'b0;
        inst_we_d    = 1'b0;
        cpu_start_d  = 1'b0;
        rx_valid_d   = 1'b0;
        data_addr_d  = DATA_ADDR;
        data_data_d  = DATA_DATA;
        inst_addr_d  = INST_ADDR;
        inst_data_d  = INST_DATA;
        rx_byte_d    = RX_BYTE;

        if (byte_valid) begin
            if (ld_state_q == SRun) begin
                rx_valid_d = 1'b1;
                rx_byte_d  = shift_q;
            end else begin
                word_d = {word_q[23:0], shift_q};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) word_valid_d = 1'b1;
            end
        end

        // Full flags mark that the top address was written; counters never wrap.
        if (word_valid_q) begin
            if (ld_state_q == SData) begin
                if (word_q == 32'hFFFF_FFFF) begin
                    ld_state_d = SInst;
                end else if (dfull_q) begin
                    err_d = 1'b1;
                end else begin
                    data_we_d   = 1'b1;
                    data_addr_d = dcnt_q;
                    data_data_d = word_q;
                    if (dcnt_q == '1) dfull_d = 1'b1;
                    else              dcnt_d  = dcnt_q + DADDR_W'(1);
                end
            end else if (ld_state_q == SInst) begin
                if (ifull_q) begin
                    err_d = 1'b1;
                end else begin
                    inst_we_d   = 1'b1;
                    inst_addr_d = icnt_q;
                    inst_data_d = word_q;
                    if (icnt_q == '1) ifull_d = 1'b1;
                    else              icnt_d  = icnt_q + IADDR_W'(1);
                end
            end
        end

        // A start edge that collides with a pending write is retried next cycle.
        if (start_req && START_EXEC && ld_state_q != SRun) begin
            if (word_valid_q) begin
                start_pend_d = 1'b1;
            end else if (ld_state_q == SInst && idx_q == 2'd0) begin
                ld_state_d  = SRun;
                cpu_start_d = 1'b1;
                done_d      = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ld_state_q   <= SData;
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            dcnt_q       <= '0;
            icnt_q       <= '0;
            dfull_q      <= 1'b0;
            ifull_q      <= 1'b0;
            start_prev_q <= 1'b0;
            start_pend_q <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            DATA_WE      <= 1'b0;
            DATA_ADDR    <= '0;
            DATA_DATA    <= '0;
            INST_WE      <= 1'b0;
            INST_ADDR    <= '0;
            INST_DATA    <= '0;
            CPU_START    <= 1'b0;
            RX_VALID     <= 1'b0;
            RX_BYTE      <= '0;
        end else begin
            ld_state_q   <= ld_state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            dcnt_q       <= dcnt_d;
            icnt_q       <= icnt_d;
            dfull_q      <= dfull_d;
            ifull_q      <= ifull_d;
            start_prev_q <= START_EXEC;
            start_pend_q <= start_pend_d;
            err_q        <= err_d;
            done_q       <= done_d;
            DATA_WE      <= data_we_d;
            DATA_ADDR    <= data_addr_d;
            DATA_DATA    <= data_data_d;
            INST_WE      <= inst_we_d;
            INST_ADDR    <= inst_addr_d;
            INST_DATA    <= inst_data_d;
            CPU_START    <= cpu_start_d;
            RX_VALID     <= rx_valid_d;
            RX_BYTE      <= rx_byte_d;
        end
    end

    assign LOAD_ERR  = err_q;
    assign LOAD_DONE = done_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader: drives UART frames and START_EXEC and logs every
// memory write, start pulse and runtime byte. The logs are compared against a
// byte/word-level model of the loader.
module tb_uart_program_loader;

    localparam int unsigned T  = 16;
    localparam int unsigned IW = 14;
    localparam int unsigned DW = 14;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          UART_RX = 1'b1;
    logic          START_EXEC = 1'b0;
    logic          INST_WE, DATA_WE, CPU_START, LOAD_DONE, RX_VALID, LOAD_ERR;
    logic [IW-1:0] INST_ADDR;
    logic [DW-1:0] DATA_ADDR;
    logic [31:0]   INST_DATA, DATA_DATA;
    logic [7:0]    RX_BYTE;

    always #5 CLK = ~CLK;

    uart_program_loader #(.T(T), .IADDR_W(IW), .DADDR_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .START_EXEC(START_EXEC),
        .INST_WE(INST_WE), .INST_ADDR(INST_ADDR), .INST_DATA(INST_DATA),
        .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR), .DATA_DATA(DATA_DATA),
        .CPU_START(CPU_START), .LOAD_DONE(LOAD_DONE), .RX_BYTE(RX_BYTE),
        .RX_VALID(RX_VALID), .LOAD_ERR(LOAD_ERR)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observed activity
    int          obs_da[$], obs_ia[$];
    logic [31:0] obs_dd[$], obs_id[$];
    logic [7:0]  obs_rx[$];
    int          n_cpu_start, n_rx_bad;

    // Reference model state and expectations
    int          exp_da[$], exp_ia[$];
    logic [31:0] exp_dd[$], exp_id[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  m_buf[$];
    int          m_mode;   // 0 data, 1 instructions, 2 running
    int          m_daddr, m_iaddr, m_starts;
    bit          m_err;

    always @(negedge CLK) begin
        if (DATA_WE) begin obs_da.push_back(int'(DATA_ADDR)); obs_dd.push_back(DATA_DATA); end
        if (INST_WE) begin obs_ia.push_back(int'(INST_ADDR)); obs_id.push_back(INST_DATA); end
        if (CPU_START) n_cpu_start++;
        if (RX_VALID) begin
            obs_rx.push_back(RX_BYTE);
            if (!LOAD_DONE) n_rx_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_mode == 2) begin
            exp_rx.push_back(b);
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                w = (32'(m_buf[0]) << 24) | (32'(m_buf[1]) << 16) | (32'(m_buf[2]) << 8)
                    | 32'(m_buf[3]);
                m_buf.delete();
                if (m_mode == 0) begin
                    if (w == 32'hFFFF_FFFF) m_mode = 1;
                    else begin exp_da.push_back(m_daddr); exp_dd.push_back(w); m_daddr++; end
                end else begin
                    exp_ia.push_back(m_iaddr); exp_id.push_back(w); m_iaddr++;
                end
            end
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        UART_RX = 1'b1;
        START_EXEC = 1'b0;
        #1;
        check("reset_outputs", {31'b0, |{INST_WE, INST_ADDR, INST_DATA, DATA_WE, DATA_ADDR,
              DATA_DATA, CPU_START, LOAD_DONE, RX_BYTE, RX_VALID, LOAD_ERR}}, 32'd0);
        repeat (3) @(posedge CLK);
        obs_da.delete(); obs_dd.delete(); obs_ia.delete(); obs_id.delete(); obs_rx.delete();
        exp_da.delete(); exp_dd.delete(); exp_ia.delete(); exp_id.delete(); exp_rx.delete();
        m_buf.delete();
        n_cpu_start = 0; n_rx_bad = 0;
        m_mode = 0; m_daddr = 0; m_iaddr = 0; m_starts = 0; m_err = 1'b0;
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        UART_RX = 1'b0;
        repeat (T) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (T) @(posedge CLK);
        end
        UART_RX = stop;
        repeat (T) @(posedge CLK);
        UART_RX = 1'b1;
        repeat (T) @(posedge CLK);
        if (stop) model_byte(b);
        else      m_err = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) uart_send(w[8*i +: 8], 1'b1);
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
        return w;
    endfunction

    task automatic pulse_start();
        START_EXEC = 1'b1;
        repeat (2) @(posedge CLK);
        START_EXEC = 1'b0;
        repeat (4) @(posedge CLK);
        if (m_mode == 1 && m_buf.size() == 0) begin
            m_mode = 2;
            m_starts++;
        end else if (m_mode != 2) begin
            m_err = 1'b1;
        end
    endtask

    task automatic compare_all(input string p);
        check({p, "_ndata"}, 32'(obs_da.size()), 32'(exp_da.size()));
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            check({p, "_daddr"}, 32'(obs_da[i]), 32'(exp_da[i]));
            check({p, "_ddata"}, obs_dd[i], exp_dd[i]);
        end
        check({p, "_ninst"}, 32'(obs_ia.size()), 32'(exp_ia.size()));
        for (int i = 0; i < obs_ia.size() && i < exp_ia.size(); i++) begin
            check({p, "_iaddr"}, 32'(obs_ia[i]), 32'(exp_ia[i]));
            check({p, "_idata"}, obs_id[i], exp_id[i]);
        end
        check({p, "_nrx"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++)
            check({p, "_rxbyte"}, 32'(obs_rx[i]), 32'(exp_rx[i]));
        check({p, "_cpu_start"}, 32'(n_cpu_start), 32'(m_starts));
        check({p, "_rx_outside_run"}, 32'(n_rx_bad), 32'd0);
        check({p, "_load_err"}, 32'(LOAD_ERR), 32'(m_err));
        check({p, "_load_done"}, 32'(LOAD_DONE), 32'(m_mode == 2));
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s1_data [9];
        s1_data = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4000_0000,
                    32'h4040_0000, 32'hBF80_0000, 32'h7F80_0000, 32'h0000_0001,
                    32'h0000_0000};

        // 1: data section, delimiter, three instructions
        do_reset();
        foreach (s1_data[i]) send_word(s1_data[i]);
        send_word(32'hFFFF_FFFF);
        send_word(32'h4F84_E200);
        send_word($urandom);
        send_word(32'hFFFF_FFFF);
        compare_all("s1");

        // 2: start execution, then runtime bytes; a second start is ignored
        repeat (100) @(posedge CLK);
        pulse_start();
        uart_send(8'h5A, 1'b1);
        for (int i = 0; i < 3; i++) uart_send(8'($urandom), 1'b1);
        pulse_start();
        compare_all("s2");

        // 3: framing error, then a good word
        do_reset();
        uart_send(8'hA5, 1'b0);
        compare_all("s3a");
        send_word(32'h0102_0304);
        compare_all("s3b");

        // 4: short glitch while idle, then a normal word
        do_reset();
        UART_RX = 1'b0;
        repeat (T / 4) @(posedge CLK);
        UART_RX = 1'b1;
        repeat (3 * T) @(posedge CLK);
        compare_all("s4a");
        send_word(rand_data());
        compare_all("s4b");

        // 5: start in data mode and start mid-word are rejected; loading continues
        do_reset();
        send_word(rand_data());
        pulse_start();
        compare_all("s5a");
        send_word(32'hFFFF_FFFF);
        uart_send(8'($urandom), 1'b1);
        uart_send(8'($urandom), 1'b1);
        pulse_start();
        compare_all("s5b");
        uart_send(8'($urandom), 1'b1);
        uart_send(8'($urandom), 1'b1);
        send_word($urandom);
        pulse_start();
        uart_send(8'($urandom), 1'b1);
        compare_all("s5c");

        // 6: reset in the middle of the third byte of an instruction word
        do_reset();
        send_word(rand_data());
        send_word(32'hFFFF_FFFF);
        uart_send(8'($urandom), 1'b1);
        uart_send(8'($urandom), 1'b1);
        UART_RX = 1'b0;
        repeat (T) @(posedge CLK);
        for (int i = 0; i < 4; i++) begin
            UART_RX = 1'($urandom);
            repeat (T) @(posedge CLK);
        end
        do_reset();
        for (int i = 0; i < 3; i++) send_word(rand_data());
        compare_all("s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
